fe_control_fsm: RTL and testbench

Multicycle control unit for the RV32I front end. It sequences the shared datapath (PC, instruction register, ALU, register file, memory port) through IDLE, FETCH, DECODE, EXECUTE, MEM and WRITEBACK, one instruction at a time. It performs req/ready handshakes with instruction and data memory, with a per-access timeout. It also keeps a retired-instruction counter and reports halt, illegal-instruction and bus-error status to the top level.

---
 rtl/fe_control_fsm.sv | 241 ++++++++++++++++++++++++
 tb/tb_fe_control_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_control_fsm.sv
// Multicycle control FSM for the RV32I front end: sequences fetch, decode,
// execute, memory and write-back, handshakes with instruction/data memory
// under a per-access timeout, and tracks retired instructions and status.
module fe_control_fsm #(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic                     branch_taken,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  output logic                     imem_req,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic [1:0]               pc_sel,
  output logic                     reg_write,
  output logic [1:0]               wb_sel,
  output logic [2:0]               state,
  output logic                     halted,
  output logic                     illegal_instr,
  output logic                     bus_error,
  output logic [INSTRET_WIDTH-1:0] instret
);

  // Wait counter only needs to reach MEM_TIMEOUT-1; a timeout or ready ends the wait there.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = TMO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  // RV32I major opcode classes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS_4   = 2'd0;
  localparam logic [1:0] PC_PLUS_IMM = 2'd1;
  localparam logic [1:0] PC_ALU_OUT  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC_4 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  state_t                   w_after_retire;
  logic [WAIT_W-1:0]        r_wait;
  logic [INSTRET_WIDTH-1:0] r_instret;
  logic                     r_halted;
  logic                     r_illegal;
  logic                     r_bus_error;

  logic w_legal;
  logic w_tmo;
  logic w_retire;
  logic w_wait_inc;
  logic w_clear_flags;
  logic w_set_halt;
  logic w_set_illegal;
  logic w_set_bus_error;

  // Opcode belongs to one of the ten RV32I classes
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: w_legal = 1'b1;
      default:                                      w_legal = 1'b0;
    endcase
  end

  assign w_tmo          = TMO_EN && (r_wait == WAIT_LAST);
  assign w_after_retire = run ? S_FETCH : S_IDLE;

  // Next-state and strobe decode from current state and opcode
  always_comb begin
    w_next_state    = r_state;
    imem_req        = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_sel          = PC_PLUS_4;
    reg_write       = 1'b0;
    wb_sel          = WB_ALU;
    w_retire        = 1'b0;
    w_wait_inc      = 1'b0;
    w_clear_flags   = 1'b0;
    w_set_halt      = 1'b0;
    w_set_illegal   = 1'b0;
    w_set_bus_error = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state  = S_FETCH;
          w_clear_flags = 1'b1;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write     = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_tmo) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_IDLE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          w_set_halt   = 1'b1;
          w_next_state = S_IDLE;
        end else if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_next_state  = S_IDLE;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEM;
          OP_BRANCH: begin
            pc_write     = 1'b1;
            pc_sel       = branch_taken ? PC_PLUS_IMM : PC_PLUS_4;
            w_retire     = 1'b1;
            w_next_state = w_after_retire;
          end
          default:           w_next_state = S_WRITEBACK;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write     = 1'b1;
            pc_sel       = PC_PLUS_4;
            w_retire     = 1'b1;
            w_next_state = w_after_retire;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (w_tmo) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_IDLE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (opcode)
          OP_JAL: begin
            pc_sel = PC_PLUS_IMM;
            wb_sel = WB_PC_4;
          end
          OP_JALR: begin
            pc_sel = PC_ALU_OUT;
            wb_sel = WB_PC_4;
          end
          OP_LOAD: begin
            pc_sel = PC_PLUS_4;
            wb_sel = WB_MEM;
          end
          default: begin
            pc_sel = PC_PLUS_4;
            wb_sel = WB_ALU;
          end
        endcase
        w_retire     = 1'b1;
        w_next_state = w_after_retire;
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // State, wait counter, retire counter and sticky status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_instret   <= '0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_wait_inc ? r_wait + WAIT_W'(1) : '0;
      if (w_retire) begin
        r_instret <= r_instret + INSTRET_WIDTH'(1);
      end
      if (w_clear_flags) begin
        r_halted    <= 1'b0;
        r_illegal   <= 1'b0;
        r_bus_error <= 1'b0;
      end else begin
        if (w_set_halt)      r_halted    <= 1'b1;
        if (w_set_illegal)   r_illegal   <= 1'b1;
        if (w_set_bus_error) r_bus_error <= 1'b1;
      end
    end
  end

  assign state         = r_state;
  assign instret       = r_instret;
  assign halted        = r_halted;
  assign illegal_instr = r_illegal;
  assign bus_error     = r_bus_error;

endmodule

// File: tb/tb_fe_control_fsm.sv
// Directed bench for fe_control_fsm with a short memory timeout and a
// narrow retire counter so both boundaries are reachable quickly.
module tb_fe_control_fsm;

  localparam int unsigned TMO = 4;
  localparam int unsigned IW  = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req;
  logic          dmem_req;
  logic          dmem_we;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_sel;
  logic          reg_write;
  logic [1:0]    wb_sel;
  logic [2:0]    state;
  logic          halted;
  logic          illegal_instr;
  logic          bus_error;
  logic [IW-1:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  fe_control_fsm #(.MEM_TIMEOUT(TMO), .INSTRET_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
    .halted(halted), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; opcode = OP_REG; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    // Reset held two cycles
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_flags", {29'd0, halted, illegal_instr, bus_error}, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_fetch", 32'(state), 32'd1);

    // R-type ADD, zero wait
    opcode = OP_REG; imem_ready = 1'b1; #1;
    chk("add_fetch_req", {30'd0, imem_req, ir_write}, 32'h3);
    tick(); imem_ready = 1'b0; #1;
    chk("add_decode", 32'(state), 32'd2);
    chk("add_decode_irw", 32'(ir_write), 32'd0);
    tick();
    chk("add_execute", 32'(state), 32'd3);
    tick();
    chk("add_wb_state", 32'(state), 32'd5);
    chk("add_wb_strobes", {27'd0, reg_write, pc_write, wb_sel, 1'b0} | 32'(pc_sel), 32'h18);
    tick();
    chk("add_next_fetch", 32'(state), 32'd1);
    chk("add_instret", 32'(instret), 32'd1);

    // LW with data ready on the fourth MEM cycle
    opcode = OP_LOAD; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      chk("lw_mem_state", 32'(state), 32'd4);
      chk("lw_mem_req_we", {30'd0, dmem_req, dmem_we}, 32'h2);
      tick();
    end
    dmem_ready = 1'b0; #1;
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    chk("lw_wb_regw", 32'(reg_write), 32'd1);
    tick();
    chk("lw_done", {28'd0, state, 1'b0} | 32'(instret) << 8, 32'h202);

    // BEQ taken then BNE not taken
    opcode = OP_BRANCH; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); branch_taken = 1'b1; #1;
    chk("beq_exec_state", 32'(state), 32'd3);
    chk("beq_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq_pcw_regw", {30'd0, pc_write, reg_write}, 32'h2);
    tick(); imem_ready = 1'b1; branch_taken = 1'b0;
    tick(); imem_ready = 1'b0;
    tick(); #1;
    chk("bne_pc_sel", 32'(pc_sel), 32'd0);
    chk("bne_pcw_regw", {30'd0, pc_write, reg_write}, 32'h2);
    tick();
    chk("branch_instret", 32'(instret), 32'd4);
    chk("branch_fetch", 32'(state), 32'd1);

    // JALR
    opcode = OP_JALR; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick();
    tick();
    chk("jalr_wb_state", 32'(state), 32'd5);
    chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
    chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
    tick();
    chk("jalr_instret", 32'(instret), 32'd5);

    // ECALL halts without retiring
    opcode = OP_SYSTEM; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    run = 1'b0;
    tick();
    chk("ecall_idle", 32'(state), 32'd0);
    chk("ecall_halted", 32'(halted), 32'd1);
    chk("ecall_instret", 32'(instret), 32'd5);
    tick();
    chk("ecall_stays_idle", {30'd0, state == 3'd0, halted}, 32'h3);
    run = 1'b1;
    tick();
    chk("restart_fetch", 32'(state), 32'd1);
    chk("restart_clr_halt", 32'(halted), 32'd0);

    // Illegal opcode
    opcode = 7'b1111111; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; run = 1'b0;
    tick();
    chk("illegal_idle", 32'(state), 32'd0);
    chk("illegal_flag", 32'(illegal_instr), 32'd1);
    chk("illegal_instret", 32'(instret), 32'd5);

    // Instruction fetch timeout
    run = 1'b1;
    tick();
    chk("tmo_clr_illegal", 32'(illegal_instr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_fetch_wait", {30'd0, state == 3'd1, imem_req}, 32'h3);
      tick();
    end
    chk("tmo_idle", 32'(state), 32'd0);
    chk("tmo_bus_error", 32'(bus_error), 32'd1);
    chk("tmo_req_drop", 32'(imem_req), 32'd0);
    chk("tmo_instret", 32'(instret), 32'd5);

    // Ready on the last allowed fetch cycle wins
    tick();
    opcode = OP_IMM;
    for (int i = 0; i < 4; i++) begin
      imem_ready = (i == 3); #1;
      chk("late_fetch_state", 32'(state), 32'd1);
      tick();
    end
    imem_ready = 1'b0;
    chk("late_decode", 32'(state), 32'd2);
    chk("late_bus_error", 32'(bus_error), 32'd0);
    tick(); tick(); tick();
    chk("late_instret", 32'(instret), 32'd6);

    // Store, zero wait
    opcode = OP_STORE; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick(); dmem_ready = 1'b1; #1;
    chk("sw_mem", {27'd0, state, dmem_req, dmem_we}, 32'h13);
    chk("sw_pcw", {29'd0, pc_write, pc_sel}, 32'h4);
    tick(); dmem_ready = 1'b0;
    chk("sw_instret", 32'(instret), 32'd7);
    chk("sw_fetch", 32'(state), 32'd1);

    // Reset during a pending store
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_mem_pending", {29'd0, state == 3'd4, dmem_req, dmem_we}, 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mem_idle", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(dmem_req), 32'd0);
    chk("rst_mem_instret", 32'(instret), 32'd0);

    // Data memory timeout
    tick();
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("dtmo_wait", {30'd0, state == 3'd4, dmem_req}, 32'h3);
      tick();
    end
    chk("dtmo_idle", {28'd0, state, bus_error}, 32'h1);
    chk("dtmo_instret", 32'(instret), 32'd0);
    tick();
    chk("dtmo_restart", {28'd0, state, bus_error}, 32'h2);

    // Retire counter wraps at its width
    opcode = OP_BRANCH;
    for (int k = 1; k <= 16; k++) begin
      imem_ready = 1'b1;
      tick(); imem_ready = 1'b0;
      tick(); tick();
      if (k >= 15) chk("instret_wrap", 32'(instret), 32'(k % 16));
    end
    chk("wrap_fetch", 32'(state), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
